mem_stage: RTL and testbench
============================

# mem_stage

Pipeline MEM stage of the RISC-V core, sitting between the EX/MEM pipeline register and the MEM/WB register. It turns load/store micro-ops into requests on the memory controller's data port (`rw_mem`/`quantity`/`status_mem` handshake), completes word loads in one cycle on a data-cache hit, and sign- or zero-extends load results. It holds the pipeline with `stall_req` until a controller transaction finishes, and passes non-memory results straight through to writeback.

## Interface
- No parameters. Widths are fixed: address 32, register 32.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rdy  in  1  global ready; when low, all state and outputs hold.
- ex_valid  in  1  EX/MEM slot holds a real instruction.
- ex_op  in  4  0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; codes 9-15 are treated as none.
- ex_rd  in  5  destination register.
- ex_we  in  1  register write enable for non-memory ops.
- ex_result  in  32  ALU result; this is the effective address for loads and stores.
- ex_store_data  in  32  store data; SB/SH use the low bits.
- rw_mem  out  2  to the controller: 0 idle, 1 read, 2 write.
- addr_mem  out  32  byte address to the controller.
- data_mem  out  32  store data to the controller.
- quantity  out  4  byte count: 1, 2 or 4.
- status_mem  in  2  from the controller: 0 idle, 1 working, 2 done.
- data_from_ctrl  in  32  load data; it is valid in the cycle where status_mem==2.
- dcache_hit  in  1  word-cache hit for the current addr_mem; combinational from ex_result.
- dcache_val  in  32  cached word.
- stall_req  out  1  combinational; freezes IF/ID/EX and the EX/MEM register.
- wb_valid, wb_we  out  1 each  registered MEM/WB outputs.
- wb_rd  out  5  registered.
- wb_data  out  32  registered.

## Operation
- The FSM has three states: IDLE, REQ and WAIT.
- IDLE, no memory op (ex_valid=0 or op none): the stage passes through.
  - wb_valid ← ex_valid, wb_we ← ex_we, wb_rd ← ex_rd, wb_data ← ex_result.
  - stall_req=0.
- IDLE, LW with dcache_hit=1:
  - wb_data ← dcache_val, wb_we ← 1, wb_valid ← 1.
  - stall_req=0 and no controller request is made.
- IDLE, any other load or store:
  - stall_req=1 and wb_valid ← 0.
  - Register rw_mem (1 for loads, 2 for stores), addr_mem ← ex_result, data_mem ← ex_store_data, quantity ← 1/2/4 by access size. Move to REQ.
- REQ:
  - Hold rw_mem, addr_mem, quantity and data_mem.
  - On status_mem==1, rw_mem ← 0 and move to WAIT. This prevents the controller from re-issuing the request when it returns to idle.
  - stall_req=1.
- WAIT: stall_req=1 until status_mem==2. In that cycle:
  - stall_req=0.
  - At the edge, wb_valid ← 1 and wb_rd ← ex_rd. Move to IDLE.
  - Loads: wb_we ← 1 and wb_data ← the extended load value.
  - Stores: wb_we ← 0 and wb_data ← 0.
- Load extension from data_from_ctrl:
  - LB: replicate bit 7 into [31:8].
  - LBU: zero [31:8].
  - LH: replicate bit 15 into [31:16].
  - LHU: zero [31:16].
  - LW: take all 32 bits.
- Stores never consult dcache_hit. Cache update on stores belongs to the controller.
- Misaligned addresses are not checked; addr_mem is passed unchanged.
- ex_* must stay stable while stall_req=1, which is guaranteed by the freeze. The stage samples ex_rd at completion.
- Writes to rd=0 are forwarded as given; the register file ignores x0.

## Timing
- Reset values: state IDLE, rw_mem 0, addr_mem 0, data_mem 0, quantity 0, wb_valid 0, wb_we 0, wb_rd 0, wb_data 0. stall_req is 0 in IDLE.
- rst mid-transaction (REQ or WAIT): return to IDLE with all of the above cleared. The controller shares rst and resets in the same cycle.
- rdy=0: no register changes. stall_req keeps its value as a function of the held state.
- Latency, pass-through and LW hit: result in MEM/WB one edge after presentation.
- Latency, miss or store, with controller accept taking A cycles and transfer taking T cycles:
  - Cycle 0: op presented, request registered at the edge.
  - REQ lasts until status_mem==1 is seen.
  - WAIT lasts until status_mem==2.
  - wb_valid rises at the edge that ends the done cycle; that cycle also has stall_req=0.
- status_mem==2 seen while in REQ (accept and done both missed): treat it as completion, exactly as in WAIT.
- In the done cycle the next EX/MEM instruction advances into EX/MEM at the same edge. The stage evaluates it from IDLE in the following cycle.

## Test plan
- ALU op (ex_op=0, rd=5, result 0x1234, we=1) → next edge wb_valid=1, wb_rd=5, wb_data=0x1234; stall_req never high.
- LW at 0x100 with dcache_hit=1 and dcache_val=0xDEADBEEF → wb_data=0xDEADBEEF one edge later, rw_mem stays 0.
- LB at 0x200 miss:
  - Stimulus: the model accepts after 1 cycle and returns done after 4 cycles with data 0x00000080.
  - Required: rw_mem=1, quantity=1 during REQ, then rw_mem=0 after accept; wb_data=0xFFFFFF80.
- LHU, same flow with data 0x0000F00F → wb_data=0x0000F00F. Repeat as LH → 0xFFFFF00F.
- SW at 0x300 with data 0xA5A5A5A5 → rw_mem=2, quantity=4, data_mem=0xA5A5A5A5; at completion wb_valid=1, wb_we=0.
- rst asserted in WAIT → next edge: state IDLE, rw_mem=0, wb_valid=0, stall_req=0. Then rdy=0 during REQ → all outputs frozen for the duration.

Source files
------------

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues load/store requests to the memory controller,
// completes LW cache hits in one cycle, and extends load data for writeback.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        ex_valid,
  input  logic [3:0]  ex_op,
  input  logic [4:0]  ex_rd,
  input  logic        ex_we,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_store_data,
  output logic [1:0]  rw_mem,
  output logic [31:0] addr_mem,
  output logic [31:0] data_mem,
  output logic [3:0]  quantity,
  input  logic [1:0]  status_mem,
  input  logic [31:0] data_from_ctrl,
  input  logic        dcache_hit,
  input  logic [31:0] dcache_val,
  output logic        stall_req,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_rw_mem;
  logic [31:0] r_addr_mem, r_data_mem, r_wb_data, w_ext;
  logic [3:0]  r_quantity, w_qty;
  logic        r_wb_valid, r_wb_we;
  logic [4:0]  r_wb_rd;
  logic        w_is_load, w_is_store, w_lw_hit, w_issue, w_accept, w_done;

  assign w_is_load  = ex_valid && (ex_op >= 4'd1) && (ex_op <= 4'd5);
  assign w_is_store = ex_valid && (ex_op >= 4'd6) && (ex_op <= 4'd8);
  assign w_lw_hit   = ex_valid && (ex_op == 4'd3) && dcache_hit;

  always_comb begin
    case (ex_op)
      4'd1, 4'd4, 4'd6: w_qty = 4'd1;
      4'd2, 4'd5, 4'd7: w_qty = 4'd2;
      default:          w_qty = 4'd4;
    endcase
  end

  always_comb begin
    case (ex_op)
      4'd1:    w_ext = {{24{data_from_ctrl[7]}}, data_from_ctrl[7:0]};
      4'd2:    w_ext = {{16{data_from_ctrl[15]}}, data_from_ctrl[15:0]};
      4'd4:    w_ext = {24'd0, data_from_ctrl[7:0]};
      4'd5:    w_ext = {16'd0, data_from_ctrl[15:0]};
      default: w_ext = data_from_ctrl;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)      r_state <= IDLE;
    else if (rdy) r_state <= w_state_nxt;
  end

  // A done seen in REQ (accept missed) completes exactly like one in WAIT.
  always_comb begin
    w_state_nxt = r_state;
    stall_req   = 1'b0;
    w_issue     = 1'b0;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if ((w_is_load || w_is_store) && !w_lw_hit) begin
          stall_req   = 1'b1;
          w_issue     = 1'b1;
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        if (status_mem == 2'd2) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          stall_req = 1'b1;
          if (status_mem == 2'd1) begin
            w_accept    = 1'b1;
            w_state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (status_mem == 2'd2) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          stall_req = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rw_mem   <= 2'd0;
      r_addr_mem <= 32'd0;
      r_data_mem <= 32'd0;
      r_quantity <= 4'd0;
      r_wb_valid <= 1'b0;
      r_wb_we    <= 1'b0;
      r_wb_rd    <= 5'd0;
      r_wb_data  <= 32'd0;
    end else if (rdy) begin
      if (w_issue) begin
        r_rw_mem   <= w_is_load ? 2'd1 : 2'd2;
        r_addr_mem <= ex_result;
        r_data_mem <= ex_store_data;
        r_quantity <= w_qty;
        r_wb_valid <= 1'b0;
      end else if (w_done) begin
        // Drop the request so the controller does not re-issue it.
        r_rw_mem   <= 2'd0;
        r_wb_valid <= 1'b1;
        r_wb_rd    <= ex_rd;
        r_wb_we    <= w_is_load;
        r_wb_data  <= w_is_load ? w_ext : 32'd0;
      end else if (w_accept) begin
        r_rw_mem <= 2'd0;
      end else if (r_state == IDLE) begin
        r_wb_valid <= ex_valid;
        r_wb_rd    <= ex_rd;
        r_wb_we    <= w_lw_hit ? 1'b1 : ex_we;
        r_wb_data  <= w_lw_hit ? dcache_val : ex_result;
      end
    end
  end

  assign rw_mem   = r_rw_mem;
  assign addr_mem = r_addr_mem;
  assign data_mem = r_data_mem;
  assign quantity = r_quantity;
  assign wb_valid = r_wb_valid;
  assign wb_we    = r_wb_we;
  assign wb_rd    = r_wb_rd;
  assign wb_data  = r_wb_data;
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus randomized ops
// against a behavioural controller and load-extension model.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst, rdy, ex_valid, ex_we, dcache_hit, stall_req, wb_valid, wb_we;
  logic [3:0]  ex_op, quantity;
  logic [4:0]  ex_rd, wb_rd;
  logic [31:0] ex_result, ex_store_data, addr_mem, data_mem, data_from_ctrl, dcache_val, wb_data;
  logic [1:0]  rw_mem, status_mem;
  int n_chk = 0, n_err = 0;

  mem_stage dut (
    .clk(clk), .rst(rst), .rdy(rdy), .ex_valid(ex_valid), .ex_op(ex_op), .ex_rd(ex_rd),
    .ex_we(ex_we), .ex_result(ex_result), .ex_store_data(ex_store_data), .rw_mem(rw_mem),
    .addr_mem(addr_mem), .data_mem(data_mem), .quantity(quantity), .status_mem(status_mem),
    .data_from_ctrl(data_from_ctrl), .dcache_hit(dcache_hit), .dcache_val(dcache_val),
    .stall_req(stall_req), .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [31:0] d);
    logic [31:0] b, h;
    b = d & 32'hFF;
    h = d & 32'hFFFF;
    case (op)
      4'd1:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
      4'd2:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      4'd4:    return b;
      4'd5:    return h;
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] ref_qty(input logic [3:0] op);
    if (op == 4'd1 || op == 4'd4 || op == 4'd6) return 4'd1;
    if (op == 4'd2 || op == 4'd5 || op == 4'd7) return 4'd2;
    return 4'd4;
  endfunction

  // Called at posedge+1; leaves the bench at posedge+1 after the op completes.
  task automatic do_op(input logic v, input logic [3:0] op, input logic [4:0] rd, input logic we,
                       input logic [31:0] res, input logic [31:0] sd, input logic hit,
                       input logic [31:0] cv, input logic [31:0] ld, input int acc,
                       input int xfer, input bit skip);
    bit is_mem, is_ld;
    is_mem = v && op >= 4'd1 && op <= 4'd8 && !(op == 4'd3 && hit);
    is_ld  = op <= 4'd5;
    ex_valid = v; ex_op = op; ex_rd = rd; ex_we = we; ex_result = res;
    ex_store_data = sd; dcache_hit = hit; dcache_val = cv; status_mem = 2'd0;
    #1 chk("stall_c0", stall_req, is_mem);
    @(posedge clk); #1;
    if (!is_mem) begin
      chk("pt_valid", wb_valid, v);
      chk("pt_rd", wb_rd, rd);
      chk("pt_we", wb_we, (v && op == 4'd3 && hit) ? 1'b1 : we);
      chk("pt_data", wb_data, (v && op == 4'd3 && hit) ? cv : res);
      chk("pt_rw", rw_mem, 0);
      return;
    end
    chk("req_rw", rw_mem, is_ld ? 2'd1 : 2'd2);
    chk("req_addr", addr_mem, res);
    chk("req_qty", quantity, ref_qty(op));
    chk("req_wdata", data_mem, sd);
    chk("req_wbv", wb_valid, 0);
    repeat (acc) begin
      #1 chk("req_stall", stall_req, 1);
      @(posedge clk); #1 chk("req_hold", rw_mem, is_ld ? 2'd1 : 2'd2);
    end
    if (!skip) begin
      status_mem = 2'd1;
      #1 chk("acc_stall", stall_req, 1);
      @(posedge clk); #1 chk("acc_rw0", rw_mem, 0);
      repeat (xfer) begin
        #1 chk("wait_stall", stall_req, 1);
        @(posedge clk); #1;
      end
    end
    status_mem = 2'd2; data_from_ctrl = ld;
    #1 chk("done_stall", stall_req, 0);
    @(posedge clk); #1;
    status_mem = 2'd0; ex_valid = 1'b0;
    chk("done_valid", wb_valid, 1);
    chk("done_rd", wb_rd, rd);
    chk("done_we", wb_we, is_ld);
    chk("done_data", wb_data, is_ld ? ref_load(op, ld) : 32'd0);
    chk("done_rw", rw_mem, 0);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; ex_valid = 0; ex_op = 0; ex_rd = 0; ex_we = 0; ex_result = 0;
    ex_store_data = 0; dcache_hit = 0; dcache_val = 0; status_mem = 0; data_from_ctrl = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_rw", rw_mem, 0); chk("rst_addr", addr_mem, 0); chk("rst_wdata", data_mem, 0);
    chk("rst_qty", quantity, 0); chk("rst_wbv", wb_valid, 0); chk("rst_wbwe", wb_we, 0);
    chk("rst_wbrd", wb_rd, 0); chk("rst_wbd", wb_data, 0); chk("rst_stall", stall_req, 0);

    // Directed cases from the plan
    do_op(1, 4'd0, 5'd5, 1, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
    do_op(1, 4'd3, 5'd6, 1, 32'h100, 0, 1, 32'hDEADBEEF, 0, 0, 0, 0);
    do_op(1, 4'd1, 5'd7, 1, 32'h200, 0, 0, 0, 32'h80, 1, 3, 0);
    do_op(1, 4'd5, 5'd8, 1, 32'h204, 0, 0, 0, 32'hF00F, 1, 3, 0);
    do_op(1, 4'd2, 5'd9, 1, 32'h204, 0, 0, 0, 32'hF00F, 1, 3, 0);
    do_op(1, 4'd8, 5'd0, 0, 32'h300, 32'hA5A5A5A5, 0, 0, 0, 1, 3, 0);
    do_op(1, 4'd4, 5'd3, 1, 32'h301, 0, 1, 0, 32'h1FF, 0, 0, 1);  // done straight from REQ
    chk("lbu_ext", wb_data, 32'hFF);

    // Reset while waiting on the controller
    ex_valid = 1; ex_op = 4'd1; ex_rd = 5'd4; ex_result = 32'h400; dcache_hit = 0;
    @(posedge clk); #1 status_mem = 2'd1;
    @(posedge clk); #1 chk("rstw_inwait", stall_req, 1);
    rst = 1'b1; ex_valid = 0; status_mem = 2'd0;
    @(posedge clk); #1 rst = 1'b0;
    chk("rstw_rw", rw_mem, 0); chk("rstw_wbv", wb_valid, 0); chk("rstw_stall", stall_req, 0);
    chk("rstw_addr", addr_mem, 0); chk("rstw_qty", quantity, 0);

    // rdy low during REQ freezes everything
    ex_valid = 1; ex_op = 4'd7; ex_rd = 5'd2; ex_result = 32'h500; ex_store_data = 32'h1234_5678;
    @(posedge clk); #1 rdy = 1'b0; status_mem = 2'd1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("frz_rw", rw_mem, 2); chk("frz_addr", addr_mem, 32'h500);
      chk("frz_qty", quantity, 2); chk("frz_wdata", data_mem, 32'h1234_5678);
      chk("frz_wbv", wb_valid, 0); chk("frz_stall", stall_req, 1);
    end
    rdy = 1'b1;
    @(posedge clk); #1 chk("frz_acc", rw_mem, 0);
    status_mem = 2'd2;
    @(posedge clk); #1 status_mem = 2'd0; ex_valid = 0;
    chk("frz_done_v", wb_valid, 1); chk("frz_done_we", wb_we, 0); chk("frz_done_rd", wb_rd, 2);

    // Randomized ops
    for (int i = 0; i < 40; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      do_op(($urandom_range(0, 7) != 0), op, 5'($urandom), 1'($urandom), $urandom, $urandom,
            1'($urandom), $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
            ($urandom_range(0, 4) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
